ddr_port_scheduler: RTL and testbench
=====================================

Name: ddr_port_scheduler

Overview:
Round-robin scheduler in the DDR clock domain. It shares the single internal burst interface of the DDR controller wrapper (acc/we/adr/dat/sel/buf_width/ack/idle) between WB_PORTS requesters. It grants one port per burst, muxes that port's command and data onto the interface, and routes acks back. It sits between the per-port clock-domain-crossing buffers and the DDR controller wrapper.

Parameters:
WB_PORTS, 3, number of requesting ports
BUF_WIDTH, {3'd3,3'd3,3'd3}, per-port burst length exponent (burst = 2^BUF_WIDTH words), 3 bits per port, port 0 in the LSBs

Ports:
local_clk_i  in  1  DDR local clock, the only clock
local_reset_n_i  in  1  asynchronous active-low reset
req_i  in  WB_PORTS  per-port level request; held for the whole burst
we_i  in  WB_PORTS  per-port write enable
adr_i  in  WB_PORTS*32  per-port burst start address
wdat_i  in  WB_PORTS*32  per-port write data
sel_i  in  WB_PORTS*4  per-port byte enables
gnt_o  out  WB_PORTS  one-hot grant
ack_o  out  WB_PORTS  per-port beat ack
rdat_o  out  32  read data, broadcast to all ports
acc_o  out  1  access request to the controller wrapper
we_o  out  1  muxed write enable
adr_o  out  32  muxed address
dat_o  out  32  muxed write data
sel_o  out  4  muxed byte enables
buf_width_o  out  4  granted port's BUF_WIDTH, zero-extended
ack_i  in  1  beat ack from the controller wrapper
dat_i  in  32  read data from the controller wrapper
idle_i  in  1  controller wrapper idle

Behaviour:
- Reset (async, local_reset_n_i=0) clears all state:
  - state=IDLE, gnt_o=0, acc_o=0, ack_o=0, beat counter=0.
  - last_gnt=WB_PORTS-1, so port 0 wins the first arbitration.
  - Muxed outputs read 0 while gnt_o=0.
  - Reset mid-burst abandons the burst immediately.
- FSM states IDLE, XFER, DONE.
- IDLE:
  - When idle_i=1 and |req_i, pick the first requesting port after last_gnt, searching cyclically upward.
  - Register gnt_o and last_gnt, clear the beat counter, go to XFER.
  - gnt_o and acc_o are high on the cycle after the req/idle sample (1-cycle latency).
  - With idle_i=0, no grant is made.
- XFER:
  - acc_o=1.
  - we_o, adr_o, dat_o, sel_o and buf_width_o are combinational muxes of the granted port's inputs.
  - Each ack_i=1 cycle: ack_o[g]=ack_i combinationally, and the beat counter (8 bits) increments.
  - When ack_i=1 and counter==2^BUF_WIDTH[g]-1: burst complete; acc_o=0 and gnt_o=0 from the next cycle; go to DONE.
  - Abort: if req_i[g] drops before completion, acc_o and gnt_o go low the next cycle, the state goes to DONE, and later ack_i pulses are not routed.
  - ack_i on the same cycle as the req drop is still routed.
- DONE:
  - acc_o=0, gnt_o=0, ack_o=0; ack_i is ignored.
  - Return to IDLE on the first cycle idle_i=1; at least one cycle is always spent in DONE.
- ack_i in IDLE or DONE is ignored.
- rdat_o=dat_i always, combinationally.
- A port may be re-granted back-to-back only if no other port requests.
- Only one bit of gnt_o may be set at any time.
- ack_o is always a subset of gnt_o.

Test Plan:
- Single request: after reset, idle_i=1, req_i=001, BUF_WIDTH[0]=3 -> gnt_o=001 and acc_o=1 one cycle later; exactly 8 ack_o[0] pulses; acc_o=0 the cycle after the 8th ack; back to IDLE once idle_i=1.
- Round-robin: req_i=111 held, 8 acks per burst, idle_i returning high after each burst -> grant order 001,010,100,001.
- Idle gating: req_i=010 with idle_i=0 for 5 cycles -> gnt_o=0 throughout; gnt_o=010 one cycle after idle_i rises.
- Abort: port 1 drops req_i after 3 acks -> acc_o=0 the next cycle; 2 further ack_i pulses give ack_o=000; no new grant until idle_i=1.
- Mux correctness: ports hold distinct adr/dat/sel/we -> adr_o/dat_o/sel_o/we_o/buf_width_o match the granted port each burst; rdat_o tracks dat_i.
- Async reset mid-burst: local_reset_n_i low during beat 4 -> gnt_o, acc_o, ack_o go 0 without a clock edge; after release with req_i=111, port 0 is granted first.

Source files
------------

// File: rtl/ddr_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module     : ddr_port_scheduler
// Description: Round-robin scheduler in the DDR local clock domain. It shares
//              the single burst interface of the DDR controller wrapper
//              between WB_PORTS requesters. One port is granted per burst.
//              That port's command and data are muxed onto the interface, and
//              beat acks are routed back to the granted port only.
// Revision   : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   local_clk_i      DDR local clock (only clock)
//   local_reset_n_i  asynchronous active-low reset
//   req_i            per-port level request, held for the whole burst
//   we_i             per-port write enable
//   adr_i            per-port burst start address (32 bits per port)
//   wdat_i           per-port write data (32 bits per port)
//   sel_i            per-port byte enables (4 bits per port)
//   gnt_o            one-hot grant (registered)
//   ack_o            per-port beat ack (subset of gnt_o)
//   rdat_o           read data, broadcast to all ports
//   acc_o            access request to the controller wrapper (registered)
//   we_o/adr_o/dat_o/sel_o  command/data of the granted port (0 when no grant)
//   buf_width_o      burst length exponent of the granted port, zero-extended
//   ack_i            beat ack from the controller wrapper
//   dat_i            read data from the controller wrapper
//   idle_i           controller wrapper idle
// ============================================================================
module ddr_port_scheduler #(
  parameter int                    WB_PORTS  = 3,
  parameter logic [3*WB_PORTS-1:0] BUF_WIDTH = {3'd3, 3'd3, 3'd3}
) (
  input  logic                     local_clk_i,
  input  logic                     local_reset_n_i,
  input  logic [WB_PORTS-1:0]      req_i,
  input  logic [WB_PORTS-1:0]      we_i,
  input  logic [WB_PORTS*32-1:0]   adr_i,
  input  logic [WB_PORTS*32-1:0]   wdat_i,
  input  logic [WB_PORTS*4-1:0]    sel_i,
  output logic [WB_PORTS-1:0]      gnt_o,
  output logic [WB_PORTS-1:0]      ack_o,
  output logic [31:0]              rdat_o,
  output logic                     acc_o,
  output logic                     we_o,
  output logic [31:0]              adr_o,
  output logic [31:0]              dat_o,
  output logic [3:0]               sel_o,
  output logic [3:0]               buf_width_o,
  input  logic                     ack_i,
  input  logic [31:0]              dat_i,
  input  logic                     idle_i
);

  localparam int              IDX_W     = (WB_PORTS > 1) ? $clog2(WB_PORTS) : 1;
  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(WB_PORTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e               state_q,    state_d;
  logic [WB_PORTS-1:0]  gnt_q,      gnt_d;
  logic                 acc_q,      acc_d;
  logic [IDX_W-1:0]     last_gnt_q, last_gnt_d;
  logic [7:0]           beat_cnt_q, beat_cnt_d;

  // Port index 'off' positions after 'base', wrapping at WB_PORTS.
  // base < WB_PORTS and off <= WB_PORTS, so a single wrap is enough.
  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base,
                                                 input int               off);
    int sum;
    sum = int'(base) + off;
    if (sum >= WB_PORTS) begin
      sum = sum - WB_PORTS;
    end
    return sum[IDX_W-1:0];
  endfunction

  // --------------------------------------------------------------------------
  // Arbitration: first requester after last_gnt, searching cyclically upward.
  // The loop runs from the farthest offset to the nearest so that the nearest
  // requesting port is the last (winning) assignment.
  // --------------------------------------------------------------------------
  logic             w_pick_valid;
  logic [IDX_W-1:0] w_pick_idx;

  always_comb begin
    w_pick_valid = 1'b0;
    w_pick_idx   = last_gnt_q;
    for (int off = WB_PORTS; off >= 1; off--) begin
      if (req_i[rr_index(last_gnt_q, off)]) begin
        w_pick_valid = 1'b1;
        w_pick_idx   = rr_index(last_gnt_q, off);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Granted-port mux. gnt_q is one-hot or zero, so an AND-OR mux suffices and
  // naturally yields zero on every muxed output when nothing is granted.
  // --------------------------------------------------------------------------
  logic        w_g_req;
  logic        w_g_we;
  logic [31:0] w_g_adr;
  logic [31:0] w_g_dat;
  logic [3:0]  w_g_sel;
  logic [2:0]  w_g_bw;

  always_comb begin
    w_g_req = 1'b0;
    w_g_we  = 1'b0;
    w_g_adr = '0;
    w_g_dat = '0;
    w_g_sel = '0;
    w_g_bw  = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (gnt_q[p]) begin
        w_g_req = w_g_req | req_i[p];
        w_g_we  = w_g_we  | we_i[p];
        w_g_adr = w_g_adr | adr_i[p*32 +: 32];
        w_g_dat = w_g_dat | wdat_i[p*32 +: 32];
        w_g_sel = w_g_sel | sel_i[p*4 +: 4];
        w_g_bw  = w_g_bw  | BUF_WIDTH[p*3 +: 3];
      end
    end
  end

  // Count value of the final beat of the granted burst (2^bw - 1).
  logic [7:0] w_last_beat;
  assign w_last_beat = 8'((9'd1 << w_g_bw) - 9'd1);

  logic w_final_ack;
  assign w_final_ack = ack_i && (beat_cnt_q == w_last_beat);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    acc_d      = acc_q;
    last_gnt_d = last_gnt_q;
    beat_cnt_d = beat_cnt_q;

    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        acc_d = 1'b0;
        if (idle_i && w_pick_valid) begin
          state_d    = ST_XFER;
          acc_d      = 1'b1;
          last_gnt_d = w_pick_idx;
          beat_cnt_d = '0;
          for (int p = 0; p < WB_PORTS; p++) begin
            gnt_d[p] = (w_pick_idx == IDX_W'(p));
          end
        end
      end

      ST_XFER: begin
        if (ack_i) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
        // Completion and abort both release the interface on the next cycle.
        if (w_final_ack || !w_g_req) begin
          state_d = ST_DONE;
          gnt_d   = '0;
          acc_d   = 1'b0;
        end
      end

      ST_DONE: begin
        gnt_d = '0;
        acc_d = 1'b0;
        if (idle_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        acc_d   = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge local_clk_i or negedge local_reset_n_i) begin
    if (!local_reset_n_i) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      acc_q      <= 1'b0;
      last_gnt_q <= LAST_PORT;   // port 0 wins the first arbitration
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      acc_q      <= acc_d;
      last_gnt_q <= last_gnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign gnt_o       = gnt_q;
  assign acc_o       = acc_q;
  // Ack routing is combinational so a beat acked on the cycle the request
  // drops still reaches the port; after that gnt_q is clear and acks vanish.
  assign ack_o       = (state_q == ST_XFER) ? (gnt_q & {WB_PORTS{ack_i}}) : '0;
  assign we_o        = w_g_we;
  assign adr_o       = w_g_adr;
  assign dat_o       = w_g_dat;
  assign sel_o       = w_g_sel;
  assign buf_width_o = {1'b0, w_g_bw};
  assign rdat_o      = dat_i;

endmodule
`default_nettype wire

// File: tb/tb_ddr_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module     : tb_ddr_port_scheduler
// Description: Self-checking bench for ddr_port_scheduler. A vector table
//              covers reset, a single burst, idle gating, re-grant and an
//              abort with a same-cycle ack; directed sequences cover the
//              round-robin order, muxing, abort and asynchronous reset.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_ddr_port_scheduler;

  localparam int              WB_PORTS  = 3;
  // port 0 = 8 beats, port 1 = 8 beats, port 2 = 4 beats
  localparam logic [8:0]      BUF_WIDTH = {3'd2, 3'd3, 3'd3};

  logic                    clk;
  logic                    rst_n;
  logic [WB_PORTS-1:0]     req_i;
  logic [WB_PORTS-1:0]     we_i;
  logic [WB_PORTS*32-1:0]  adr_i;
  logic [WB_PORTS*32-1:0]  wdat_i;
  logic [WB_PORTS*4-1:0]   sel_i;
  logic [WB_PORTS-1:0]     gnt_o;
  logic [WB_PORTS-1:0]     ack_o;
  logic [31:0]             rdat_o;
  logic                    acc_o;
  logic                    we_o;
  logic [31:0]             adr_o;
  logic [31:0]             dat_o;
  logic [3:0]              sel_o;
  logic [3:0]              buf_width_o;
  logic                    ack_i;
  logic [31:0]             dat_i;
  logic                    idle_i;

  ddr_port_scheduler #(
    .WB_PORTS  (WB_PORTS),
    .BUF_WIDTH (BUF_WIDTH)
  ) dut (
    .local_clk_i     (clk),
    .local_reset_n_i (rst_n),
    .req_i           (req_i),
    .we_i            (we_i),
    .adr_i           (adr_i),
    .wdat_i          (wdat_i),
    .sel_i           (sel_i),
    .gnt_o           (gnt_o),
    .ack_o           (ack_o),
    .rdat_o          (rdat_o),
    .acc_o           (acc_o),
    .we_o            (we_o),
    .adr_o           (adr_o),
    .dat_o           (dat_o),
    .sel_o           (sel_o),
    .buf_width_o     (buf_width_o),
    .ack_i           (ack_i),
    .dat_i           (dat_i),
    .idle_i          (idle_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Per-port stimulus and the values the mux must reproduce.
  logic [31:0] port_adr [WB_PORTS];
  logic [31:0] port_dat [WB_PORTS];
  logic [3:0]  port_sel [WB_PORTS];
  logic        port_we  [WB_PORTS];
  logic [3:0]  port_bw  [WB_PORTS];
  int          port_beats [WB_PORTS];

  typedef struct {
    logic [2:0] req;
    logic       idle;
    logic       ack;
    logic [2:0] exp_gnt;
    logic       exp_acc;
    logic [2:0] exp_ack;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [2:0] req, input logic idle, input logic ack,
                         input logic [2:0] g, input logic a, input logic [2:0] k);
    vec_t v;
    v.req = req; v.idle = idle; v.ack = ack;
    v.exp_gnt = g; v.exp_acc = a; v.exp_ack = k;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    req_i  = '0;
    idle_i = 1'b0;
    ack_i  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One full burst of port p from IDLE: grant, mux checks, beats, DONE, back
  // to IDLE. req_i must already contain p and p must be the expected winner.
  task automatic run_burst(input int p, input string tag);
    logic [2:0] onehot;
    onehot = 3'(1 << p);
    idle_i = 1'b1;
    ack_i  = 1'b0;
    #1;
    check({tag, "_pre_gnt"}, 32'(gnt_o), 32'd0);
    tick();
    check({tag, "_gnt"}, 32'(gnt_o), 32'(onehot));
    check({tag, "_acc"}, 32'(acc_o), 32'd1);
    check({tag, "_adr"}, adr_o, port_adr[p]);
    check({tag, "_dat"}, dat_o, port_dat[p]);
    check({tag, "_sel"}, 32'(sel_o), 32'(port_sel[p]));
    check({tag, "_we"},  32'(we_o),  32'(port_we[p]));
    check({tag, "_bw"},  32'(buf_width_o), 32'(port_bw[p]));
    idle_i = 1'b0;
    for (int b = 0; b < port_beats[p]; b++) begin
      ack_i = 1'b1;
      dat_i = $urandom;
      #1;
      check($sformatf("%s_ack%0d", tag, b), 32'(ack_o), 32'(onehot));
      check($sformatf("%s_rdat%0d", tag, b), rdat_o, dat_i);
      tick();
    end
    ack_i = 1'b0;
    #1;
    check({tag, "_end_gnt"}, 32'(gnt_o), 32'd0);
    check({tag, "_end_acc"}, 32'(acc_o), 32'd0);
    idle_i = 1'b1;
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int p = 0; p < WB_PORTS; p++) begin
      port_adr[p]   = 32'hA000_0000 + 32'(p) * 32'h0101_0110;
      port_dat[p]   = 32'h5A5A_0000 ^ (32'(p + 1) * 32'h0013_1717);
      port_sel[p]   = 4'(4'b0001 << p) | 4'b1000;
      port_we[p]    = (p != 1);
      port_bw[p]    = {1'b0, BUF_WIDTH[p*3 +: 3]};
      port_beats[p] = 1 << BUF_WIDTH[p*3 +: 3];
      adr_i[p*32 +: 32] = port_adr[p];
      wdat_i[p*32 +: 32] = port_dat[p];
      sel_i[p*4 +: 4]   = port_sel[p];
      we_i[p]           = port_we[p];
    end
    dat_i = 32'h0;

    // ---------------- reset state ----------------
    rst_n  = 1'b0;
    req_i  = 3'b111;
    idle_i = 1'b1;
    ack_i  = 1'b1;
    #2;
    check("rst_gnt", 32'(gnt_o), 32'd0);
    check("rst_acc", 32'(acc_o), 32'd0);
    check("rst_ack", 32'(ack_o), 32'd0);
    check("rst_adr", adr_o, 32'd0);
    do_reset();

    // ---------------- vector table ----------------
    //       req     idle  ack   gnt     acc   ack_o
    add_vec(3'b001, 1'b1, 1'b1, 3'b000, 1'b0, 3'b000); // IDLE ignores ack
    for (int b = 0; b < 8; b++)
      add_vec(3'b001, 1'b0, 1'b1, 3'b001, 1'b1, 3'b001); // 8 beats
    add_vec(3'b001, 1'b0, 1'b1, 3'b000, 1'b0, 3'b000); // DONE ignores ack
    add_vec(3'b001, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000); // DONE -> IDLE
    add_vec(3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000); // IDLE, no request
    add_vec(3'b001, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000); // idle_i low: no grant
    add_vec(3'b001, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000); // grant sampled
    add_vec(3'b001, 1'b0, 1'b0, 3'b001, 1'b1, 3'b000); // re-grant port 0
    add_vec(3'b000, 1'b0, 1'b1, 3'b001, 1'b1, 3'b001); // drop with ack: routed
    add_vec(3'b000, 1'b0, 1'b1, 3'b000, 1'b0, 3'b000); // aborted: DONE
    add_vec(3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000); // DONE -> IDLE
    add_vec(3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000);

    foreach (vecs[i]) begin
      req_i  = vecs[i].req;
      idle_i = vecs[i].idle;
      ack_i  = vecs[i].ack;
      #1;
      check($sformatf("vec%0d_gnt", i), 32'(gnt_o), 32'(vecs[i].exp_gnt));
      check($sformatf("vec%0d_acc", i), 32'(acc_o), 32'(vecs[i].exp_acc));
      check($sformatf("vec%0d_ack", i), 32'(ack_o), 32'(vecs[i].exp_ack));
      tick();
    end

    // ---------------- round-robin with mux checks ----------------
    do_reset();
    req_i = 3'b111;
    run_burst(0, "rr0");
    run_burst(1, "rr1");
    run_burst(2, "rr2");
    run_burst(0, "rr3");

    // ---------------- idle gating ----------------
    req_i  = 3'b010;
    idle_i = 1'b0;
    ack_i  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("gate%0d_gnt", c), 32'(gnt_o), 32'd0);
      tick();
    end
    idle_i = 1'b1;
    tick();
    check("gate_gnt", 32'(gnt_o), 32'b010);
    check("gate_acc", 32'(acc_o), 32'd1);
    idle_i = 1'b0;

    // ---------------- abort after 3 acks ----------------
    for (int b = 0; b < 3; b++) begin
      ack_i = 1'b1;
      #1;
      check($sformatf("abort_ack%0d", b), 32'(ack_o), 32'b010);
      tick();
    end
    ack_i = 1'b0;
    req_i = 3'b000;
    tick();
    check("abort_acc", 32'(acc_o), 32'd0);
    check("abort_gnt", 32'(gnt_o), 32'd0);
    for (int b = 0; b < 2; b++) begin
      ack_i = 1'b1;
      #1;
      check($sformatf("abort_late_ack%0d", b), 32'(ack_o), 32'd0);
      tick();
    end
    ack_i = 1'b0;
    req_i = 3'b010;
    for (int c = 0; c < 2; c++) begin
      #1;
      check($sformatf("abort_hold%0d_gnt", c), 32'(gnt_o), 32'd0);
      tick();
    end
    idle_i = 1'b1;
    tick();                                   // DONE -> IDLE
    check("abort_idle_gnt", 32'(gnt_o), 32'd0);
    tick();                                   // grant registered
    check("abort_regnt", 32'(gnt_o), 32'b010);
    idle_i = 1'b0;

    // ---------------- asynchronous reset during beat 4 ----------------
    for (int b = 0; b < 3; b++) begin
      ack_i = 1'b1;
      tick();
    end
    ack_i = 1'b1;
    #1;
    check("arst_beat4_ack", 32'(ack_o), 32'b010);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_gnt", 32'(gnt_o), 32'd0);
    check("arst_acc", 32'(acc_o), 32'd0);
    check("arst_ack", 32'(ack_o), 32'd0);
    #1;
    rst_n  = 1'b1;
    ack_i  = 1'b0;
    req_i  = 3'b111;
    idle_i = 1'b1;
    tick();
    check("arst_first_gnt", 32'(gnt_o), 32'b001);
    check("arst_first_acc", 32'(acc_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
